// File: rtl/csa_resolver.sv
// csa_resolver: converts a carry-save (Sum, Carry) pair into a binary value.
// The addition ripples through CHUNK bits per cycle, so the carry chain stays
// short at the cost of NCHUNK cycles per operation.
// Optional feature: define CSA_RESOLVER_OVF_EN to add a sticky overflow flag
// (ports clr_ovf_i / ovf_o) that records any delivered result with its MSB set.
module csa_resolver #(
  parameter int XLEN  = 49,
  parameter int CHUNK = 8
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [XLEN-1:0] Sum_i,
  input  logic [XLEN-1:0] Carry_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN:0]   Result_o
`ifdef CSA_RESOLVER_OVF_EN
  ,
  input  logic            clr_ovf_i,
  output logic            ovf_o
`endif
);

  localparam int RW     = XLEN + 1;
  localparam int NCHUNK = (RW + CHUNK - 1) / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CW     = CHUNK + 1;
  localparam logic [KW-1:0] LAST_K = KW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [KW-1:0]   r_k;
  logic            r_cin;
  logic            r_outValid;
  logic [RW-1:0]   r_opA;
  logic [RW-1:0]   r_opB;
  logic [RW-1:0]   r_result;

  int              w_shamt;
  logic [CHUNK-1:0] w_aChunk;
  logic [CHUNK-1:0] w_bChunk;
  logic [CW-1:0]   w_chunkAdd;
  logic [CHUNK-1:0] w_chunkSum;
  logic            w_chunkCout;
  logic [RW-1:0]   w_mask;
  logic [RW-1:0]   w_resultNext;
  logic            w_accept;
  logic            w_handshake;

  // Slice out the current chunk of both operands, add them with the carry-in
  // and merge the chunk sum into the partially built result. Bits shifted past
  // the top of the result vector fall off, which truncates the last chunk.
  always_comb begin
    w_shamt      = int'(r_k) * CHUNK;
    w_aChunk     = CHUNK'(r_opA >> w_shamt);
    w_bChunk     = CHUNK'(r_opB >> w_shamt);
    w_chunkAdd   = {1'b0, w_aChunk} + {1'b0, w_bChunk} + CW'(r_cin);
    w_chunkSum   = w_chunkAdd[CHUNK-1:0];
    w_chunkCout  = w_chunkAdd[CHUNK];
    w_mask       = RW'({CHUNK{1'b1}}) << w_shamt;
    w_resultNext = (r_result & ~w_mask) | (RW'(w_chunkSum) << w_shamt);
  end

  assign in_ready_o  = (r_state == IDLE);
  assign w_accept    = in_valid_i & in_ready_o;
  assign w_handshake = r_outValid & out_ready_i;
  assign out_valid_o = r_outValid;
  assign Result_o    = r_result;

  // Control FSM plus datapath registers: capture in IDLE, one chunk per ADD
  // cycle, then hold the result in DONE until the consumer takes it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= IDLE;
      r_k        <= '0;
      r_cin      <= 1'b0;
      r_outValid <= 1'b0;
      r_opA      <= '0;
      r_opB      <= '0;
      r_result   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_opA   <= {1'b0, Sum_i};
            r_opB   <= {Carry_i, 1'b0};
            r_k     <= '0;
            r_cin   <= 1'b0;
            r_state <= ADD;
          end
        end
        ADD: begin
          r_result <= w_resultNext;
          if (r_k == LAST_K) begin
            // The final carry-out is always zero for a legal carry-save pair.
            r_cin      <= 1'b0;
            r_k        <= '0;
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_cin <= w_chunkCout;
            r_k   <= r_k + KW'(1);
          end
        end
        DONE: begin
          if (w_handshake) begin
            r_outValid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_outValid <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

`ifdef CSA_RESOLVER_OVF_EN
  logic r_ovf;

  // Sticky overflow flag: set when a delivered result has its MSB set; a set
  // in the same cycle as a clear wins so no overflow event is ever lost.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_ovf <= 1'b0;
    end else if (w_handshake && r_result[XLEN]) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf_i) begin
      r_ovf <= 1'b0;
    end
  end

  assign ovf_o = r_ovf;
`else
  // Without the overflow option the result MSB is only visible on Result_o.
`endif

endmodule

// File: tb/tb_csa_resolver.sv
// tb_csa_resolver: directed and randomized checks of csa_resolver against an
// arithmetic reference (Result = Sum + 2*Carry, XLEN+1 bits wide).
module tb_csa_resolver;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [48:0] Sum;
  logic [48:0] Carry;
  logic        out_valid;
  logic        out_ready;
  logic [49:0] Result;
`ifdef CSA_RESOLVER_OVF_EN
  logic        clr_ovf;
  logic        ovf;
  logic        ovfModel;
`endif

  int total;
  int bad;

  csa_resolver dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .Sum_i      (Sum),
    .Carry_i    (Carry),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .Result_o   (Result)
`ifdef CSA_RESOLVER_OVF_EN
    ,
    .clr_ovf_i  (clr_ovf),
    .ovf_o      (ovf)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so a stuck design can never hang the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] refModel(input logic [48:0] s, input logic [48:0] c);
    logic [63:0] v;
    v = 64'(s) + (64'(c) * 64'd2);
    return v % (64'd1 << 50);
  endfunction

  function automatic logic [48:0] rand49();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[48:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, run ADD while scribbling on the idle
  // inputs, check latency and result, optionally stall in DONE, then release.
  task automatic applyStimulus(input logic [48:0] s, input logic [48:0] c, input int holdCycles);
    logic [63:0] exp;
    int lat;
    exp = refModel(s, c);
    Sum = s;
    Carry = c;
    in_valid = 1'b1;
    out_ready = (holdCycles == 0);
    tick();
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      in_valid = 1'($urandom_range(0, 1));
      Sum = rand49();
      Carry = rand49();
      tick();
      lat++;
    end
    in_valid = 1'b0;
    checkOutput("latency", 64'(lat), 64'd8);
    checkOutput("result", 64'(Result), exp);
    checkOutput("inReadyInDone", 64'(in_ready), 64'd0);
    for (int i = 0; i < holdCycles; i++) begin
      tick();
      checkOutput("stallValid", 64'(out_valid), 64'd1);
      checkOutput("stallInReady", 64'(in_ready), 64'd0);
      checkOutput("stallResult", 64'(Result), exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("idleInReady", 64'(in_ready), 64'd1);
    checkOutput("idleValid", 64'(out_valid), 64'd0);
`ifdef CSA_RESOLVER_OVF_EN
    ovfModel = ovfModel | exp[49];
    checkOutput("ovf", 64'(ovf), 64'(ovfModel));
`endif
  endtask

  initial begin
    int seen;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    Sum = '0;
    Carry = '0;
`ifdef CSA_RESOLVER_OVF_EN
    clr_ovf = 1'b0;
    ovfModel = 1'b0;
`endif
    $display("[TB] start");

    // Reset values
    #2;
    checkOutput("rstInReady", 64'(in_ready), 64'd1);
    checkOutput("rstValid", 64'(out_valid), 64'd0);
    checkOutput("rstResult", 64'(Result), 64'd0);
`ifdef CSA_RESOLVER_OVF_EN
    checkOutput("rstOvf", 64'(ovf), 64'd0);
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Simplest value, ripple across chunk boundary, full-width overflow
    applyStimulus(49'd1, 49'd0, 0);
    applyStimulus(49'hFF, 49'h1, 0);
    applyStimulus({49{1'b1}}, 49'd1, 0);
`ifdef CSA_RESOLVER_OVF_EN
    tick();
    checkOutput("ovfHeld", 64'(ovf), 64'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    ovfModel = 1'b0;
    checkOutput("ovfCleared", 64'(ovf), 64'd0);
`endif

    // Consumer back-pressure for five cycles in DONE
    applyStimulus(rand49(), rand49(), 5);

    // Reset during the third ADD cycle abandons the operation
    Sum = rand49();
    Carry = rand49();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checkOutput("midRstValid", 64'(out_valid), 64'd0);
    checkOutput("midRstResult", 64'(Result), 64'd0);
    checkOutput("midRstInReady", 64'(in_ready), 64'd1);
`ifdef CSA_RESOLVER_OVF_EN
    ovfModel = 1'b0;
`endif
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid !== 1'b0) seen++;
    end
    checkOutput("noResultAfterRst", 64'(seen), 64'd0);
    applyStimulus(49'd5, 49'd3, 0);

    // Randomized operands with random back-pressure
    for (int n = 0; n < 10; n++) begin
      applyStimulus(rand49(), rand49(), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/csa_resolver.md
CSA_RESOLVER -- requirements
Module: csa_resolver

Interface
REQ-001 SHALL have parameter XLEN, default 49: width of the carry-save Sum and Carry input vectors.
REQ-002 SHALL have parameter CHUNK, default 8: number of result bits resolved per cycle; legal range 1..XLEN+1.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid_i, input, 1 bit: the upstream Sum_i/Carry_i pair is valid.
REQ-006 SHALL have port in_ready_o, output, 1 bit: the block can accept an operand pair.
REQ-007 SHALL have port Sum_i, input, XLEN bits: carry-save sum vector, bit j has weight 2^j.
REQ-008 SHALL have port Carry_i, input, XLEN bits: carry-save carry vector, bit j has weight 2^(j+1).
REQ-009 SHALL have port out_valid_o, output, 1 bit: Result_o holds a resolved value.
REQ-010 SHALL have port out_ready_i, input, 1 bit: downstream accepts Result_o.
REQ-011 SHALL have port Result_o, output, XLEN+1 bits: binary value Sum_i + (Carry_i << 1).

Function
REQ-012 SHALL define NCHUNK = ceil((XLEN+1)/CHUNK), which is 7 for the defaults.
REQ-013 SHALL implement FSM states IDLE, ADD, DONE.
REQ-014 SHALL assert in_ready_o only in IDLE.
REQ-015 SHALL accept an operand pair only when in_valid_i=1 and in_ready_o=1, capturing Sum_i and (Carry_i<<1) zero-extended to XLEN+1 bits, clearing the chunk counter and carry-in register, and moving to ADD.
REQ-016 SHALL, in ADD, add chunk k of both operands plus the registered carry-in, write the CHUNK-bit sum into bits [k*CHUNK +: CHUNK] of the result register (truncated at bit XLEN for the last chunk), register the chunk carry-out, and increment k.
REQ-017 SHALL move from ADD to DONE after the cycle that processes chunk NCHUNK-1, so that ADD lasts exactly NCHUNK cycles.
REQ-018 SHALL discard the carry-out of the last chunk; for legal carry-save inputs it is always 0.
REQ-019 SHALL assert out_valid_o only in DONE and hold Result_o stable while out_valid_o=1 and out_ready_i=0.
REQ-020 SHALL return from DONE to IDLE on out_valid_o=1 and out_ready_i=1; the block does not accept new input in the same cycle, giving a throughput of one result per NCHUNK+2 cycles.
REQ-021 SHALL ignore in_valid_i, Sum_i and Carry_i outside IDLE, and ignore out_ready_i outside DONE.
REQ-022 SHALL give an accept-to-out_valid_o latency of NCHUNK+1 cycles, which is 8 for the defaults.

Reset
REQ-023 SHALL, while rst_n_i=0, immediately force the FSM to IDLE, the chunk counter, carry-in register and result register to 0, and produce in_ready_o=1 (combinationally, from the IDLE state), out_valid_o=0 and Result_o=0.
REQ-024 SHALL abandon any in-flight operation when reset is asserted mid-ADD or mid-DONE, with no output handshake for that operation.

Configuration
REQ-025 SHALL, when macro CSA_RESOLVER_OVF_EN is defined, add port clr_ovf_i (input, 1 bit) and port ovf_o (output, 1 bit, reset value 0).
REQ-026 SHALL, with CSA_RESOLVER_OVF_EN defined, set ovf_o on the cycle after any output handshake whose Result_o[XLEN]=1, keep it set until clr_ovf_i=1 or reset, and let the set take priority when set and clear occur in the same cycle.
REQ-027 SHALL, when CSA_RESOLVER_OVF_EN is not defined, have neither ports clr_ovf_i nor ovf_o nor their register, with all other behaviour identical.

Verification
REQ-028 SHALL cover: Sum_i=1, Carry_i=0, out_ready_i=1 -> Result_o=1 with out_valid_o rising exactly 8 cycles after accept.
REQ-029 SHALL cover: Sum_i=0xFF, Carry_i=0x1 -> Result_o=0x101, proving carry ripple across the chunk 0/1 boundary.
REQ-030 SHALL cover: Sum_i=2^49-1, Carry_i=1 -> Result_o=0x2_0000_0000_0001 and, with CSA_RESOLVER_OVF_EN defined, ovf_o=1 after the handshake until clr_ovf_i is pulsed.
REQ-031 SHALL cover: out_ready_i held at 0 for 5 cycles in DONE -> Result_o stable, out_valid_o=1 and in_ready_o=0 throughout, with IDLE reached the cycle after out_ready_i=1.
REQ-032 SHALL cover: rst_n_i pulsed low during the third ADD cycle -> out_valid_o=0 and Result_o=0 immediately, no result delivered, and a subsequent transaction Sum_i=5, Carry_i=3 -> Result_o=11.
REQ-033 SHALL cover: in_valid_i toggled with changing data during ADD -> Result_o unaffected by that data.
